// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: TX FSM states, parity modes,
// and the frame length in bit times.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with extended pointers; full is a registered
// compare so it can drive a ready output directly. Shared by the TX and RX paths.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && (wptr_q != rptr_q);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    // Full looks only at the current occupancy, so a same-cycle pop never opens the port.
    full_d  = ((wptr_d - rptr_d) == DEPTH_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rptr_q[AW-1:0]];
  assign count    = wptr_q - rptr_q;
  assign full     = full_q;
  assign empty    = (wptr_q == rptr_q);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: configurable baud divisor, data width,
// parity and stop bits; frames go out back to back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY == PAR_ODD);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  txd_q, txd_d;

  logic                  bit_done;
  logic                  fifo_pop;
  logic [DATA_BITS-1:0]  fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // txd_d is the value for the bit that starts on the coming edge, so the
  // serial line is a plain flop aligned with the state register.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    bit_done = (baud_q == BAUD_LAST);

    if (state_q != ST_IDLE) baud_d = bit_done ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          par_d    = 1'b0;
          baud_d   = '0;
          txd_d    = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_q == DATA_LAST) begin
            if (PARITY != PAR_NONE) begin
              txd_d   = par_q ^ ODD_PAR;
              state_d = ST_PARITY;
            end else begin
              txd_d   = 1'b1;
              bit_d   = '0;
              state_d = ST_STOP;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          txd_d   = 1'b1;
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_q == STOP_LAST) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_data;
              par_d    = 1'b0;
              txd_d    = 1'b0;
              state_d  = ST_START;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign wr_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, synthesizable UART transmitter with an input FIFO for the femtoRV SoC. It replaces the fixed 8N1, one-byte-at-a-time serial stimulus used around `SOC_flash`. CPU or bench logic pushes words through a valid/ready port, and the block serialises them on `txd` with configurable baud divisor, data width, parity and stop bits. Frames are sent back to back with no idle gap while the FIFO holds data.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per serial bit (25 MHz / 115200). Legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame. Legal range 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame. Legal values 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2, ≥ 2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_data`  in  DATA_BITS  word to transmit; bit 0 is sent first.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  high when the FIFO is not full. A push occurs on an edge where `wr_valid && wr_ready`.
- `txd`  out  1  serial output; idles high.
- `busy`  out  1  high while a frame is being shifted out or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries; excludes the word held in the shifter.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Bit timer:** a baud counter counts 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
- **IDLE:** `txd`=1. When the FIFO is non-empty, pop the head into the shift register, clear the parity accumulator, and go to START.
- **START:** `txd`=0 for one bit time, then go to DATA.
- **DATA:** `txd` = shifter LSB. Shift right and XOR the sent bit into the parity accumulator each bit time. After DATA_BITS bits, go to PARITY if `PARITY`≠0, otherwise go to STOP.
- **PARITY:** `txd` = accumulator XOR (PARITY==1). This is the even-parity bit, inverted for odd.
- **STOP:** `txd`=1 for STOP_BITS bit times.
  - On the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START (no idle bit).
  - Otherwise go to IDLE.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **FIFO:** circular, with read/write pointers one bit wider than the address. `wr_ready` = (`fifo_count` ≠ FIFO_DEPTH).
  - A simultaneous push and pop leaves the count unchanged.
  - While full, `wr_ready` is low even if a pop occurs in the same cycle. There is no bypass.
  - Words are transmitted strictly in push order. A push is never dropped; the handshake guarantees this.
- **Reset values:** `txd`=1, `wr_ready`=1, `busy`=0, `fifo_count`=0, FSM=IDLE, baud counter=0.
- **Reset mid-frame:** the frame is aborted, `txd` returns to 1 asynchronously, and the FIFO contents are discarded. After reset is released there is no residual output.

## Timing
- Push at edge N → `fifo_count` updates at edge N. If the FSM was IDLE: pop and `txd` falls at edge N+1.
- `txd` is registered. Every transition occurs on a `clk` edge that is a multiple of CLKS_PER_BIT after the start-bit edge.
- `busy` rises at the push edge and falls at the edge where STOP completes with the FIFO empty.
- `wr_ready` is a registered compare; it changes at the same edge as `fifo_count`.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Parity mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
  - A function that returns frame length in bits.
- One sub-module, `sync_fifo`, parametrised by WIDTH and DEPTH, with push/pop/count/full/empty. It is reused by the future RX path.
- The top level holds the FSM, baud counter, shifter and parity accumulator.

## Test plan
- **Reset:** hold `reset` for 5 cycles with `wr_valid`=1 → `txd`=1, `wr_ready`=1, `busy`=0, `fifo_count`=0 throughout, and no frame after release until a fresh push.
- **Single word:** push 0x34 with defaults → `txd` low 217 cycles starting the edge after the push, then 0,0,1,0,1,1,0,0 at 217 cycles each, then stop high. `busy` falls exactly 2170 cycles after the start edge.
- **Burst:** push 0x34,0x2A,0x34,0x39,0x2F,0x30 on consecutive cycles → six contiguous frames totalling 13020 cycles, with no high gap beyond stop bits. A UART monitor decodes the same six bytes in order.
- **Parity and stop bits:**
  - PARITY=2, STOP_BITS=2, push 0x2A → parity bit 1, 12-bit frame, 2604 cycles.
  - PARITY=1, push 0x2A → parity bit 0.
- **FIFO full:** 18 consecutive push attempts from idle → 17 accepted (one moves into the shifter) and `fifo_count` reaches 16. `wr_ready` is low for the 18th attempt until the first frame ends. All 17 words are emitted in order.
- **Reset mid-frame:** assert `reset` during data bit 3 of the first of 4 queued words → `txd`=1 within the same cycle, `fifo_count`=0, and no frame after release.
